// File: rtl/vx_issue_pkg.sv
// Shared types and constants for the warp issue scheduler.
// NW_BITS is the warp-id width for the default 4-warp configuration.
package vx_issue_pkg;

  localparam int NUM_WARPS_DEF = 4;
  localparam int NW_BITS       = $clog2(NUM_WARPS_DEF);

  // IDLE: no grant outstanding; GRANT: issue_valid is high
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vx_warp_rr_pick.sv
// Combinational find-first-set starting at a rotating pointer.
// The mask is rotated so that bit ptr lands at position 0; the lowest set
// bit of the rotated mask is the winner, translated back by adding ptr.
// N must be a power of two so the index add wraps naturally.
module vx_warp_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_index,
  output logic [N-1:0]  o_onehot
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;

  // rotate the request mask so the pointer position becomes bit 0
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_rot[gi] = i_mask[i_ptr + IW'(gi)];
  end

  // lowest set bit of the rotated mask, mapped back to an absolute index
  always_comb begin
    w_off   = '0;
    o_valid = |i_mask;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    o_index  = i_ptr + w_off;
    o_onehot = o_valid ? (N'(1) << o_index) : '0;
  end

endmodule

// File: rtl/vx_warp_issue_sched.sv
// Warp issue scheduler: masks scoreboard-stalled warps, round-robins among
// the eligible ones and holds a registered grant under a valid/ready
// handshake. Optional starvation guard enabled by ISSUE_STARVE_GUARD_EN.
module vx_warp_issue_sched
  import vx_issue_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         req_valid,
  input  logic [NUM_WARPS-1:0]         req_stall,
  input  logic                         issue_ready,
  output logic                         issue_valid,
  output logic [$clog2(NUM_WARPS)-1:0] issue_wid,
  output logic [NUM_WARPS-1:0]         issue_onehot,
  output logic [NUM_WARPS-1:0]         deq
);

  localparam int WB = $clog2(NUM_WARPS);

  sched_state_e         r_state, r_state_next;
  logic [WB-1:0]        r_wid, r_wid_next;
  logic [WB-1:0]        r_ptr, r_ptr_next;
  logic [NUM_WARPS-1:0] r_onehot, r_onehot_next;

  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_elig_nx;
  logic                 w_fire;
  logic [WB-1:0]        w_pick_ptr;

  logic                 w_rr_valid;
  logic [WB-1:0]        w_rr_idx;
  logic [NUM_WARPS-1:0] w_rr_onehot;

  logic [NUM_WARPS-1:0] w_starve;
  logic                 w_st_valid;
  logic [WB-1:0]        w_st_idx;
  logic [NUM_WARPS-1:0] w_st_onehot;

  logic                 w_pick_valid;
  logic [WB-1:0]        w_pick_idx;
  logic [NUM_WARPS-1:0] w_pick_onehot;

  assign w_elig = req_valid & ~req_stall;
  assign w_fire = (r_state == GRANT) & issue_ready;

  // candidate set for the next pick: a warp that just fired stays a
  // candidate only while its queue still holds an instruction, and the
  // pointer moves past it so it becomes lowest priority
  always_comb begin
    w_elig_nx  = w_elig;
    w_pick_ptr = r_ptr;
    if (w_fire) begin
      w_elig_nx[r_wid] = req_valid[r_wid];
      w_pick_ptr       = r_wid + WB'(1);
    end
  end

  vx_warp_rr_pick #(.N(NUM_WARPS), .IW(WB)) u_rr_pick (
    .i_mask   (w_elig_nx),
    .i_ptr    (w_pick_ptr),
    .o_valid  (w_rr_valid),
    .o_index  (w_rr_idx),
    .o_onehot (w_rr_onehot)
  );

`ifdef ISSUE_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_starve
    logic [CW-1:0] r_cnt;

    // count cycles a warp is eligible but not served; serving or an empty queue clears it
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else if ((w_fire && (r_wid == WB'(gi))) || !req_valid[gi]) begin
        r_cnt <= '0;
      end else if (w_elig[gi] && (r_cnt != CW'(STARVE_LIMIT))) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    // a warp being served this cycle cannot be starving for the next pick
    assign w_starve[gi] = w_elig_nx[gi] & (r_cnt == CW'(STARVE_LIMIT)) &
                          ~(w_fire & (r_wid == WB'(gi)));
  end

  vx_warp_rr_pick #(.N(NUM_WARPS), .IW(WB)) u_starve_pick (
    .i_mask   (w_starve),
    .i_ptr    ({WB{1'b0}}),
    .o_valid  (w_st_valid),
    .o_index  (w_st_idx),
    .o_onehot (w_st_onehot)
  );
`else
  assign w_starve    = '0;
  assign w_st_valid  = 1'b0;
  assign w_st_idx    = '0;
  assign w_st_onehot = '0;
`endif

  // a starving warp overrides the round-robin choice
  always_comb begin
    w_pick_valid  = w_rr_valid;
    w_pick_idx    = w_rr_idx;
    w_pick_onehot = w_rr_onehot;
    if (w_st_valid) begin
      w_pick_idx    = w_st_idx;
      w_pick_onehot = w_st_onehot;
    end
  end

  // grant, pointer and state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wid    <= '0;
      r_ptr    <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= r_state_next;
      r_wid    <= r_wid_next;
      r_ptr    <= r_ptr_next;
      r_onehot <= r_onehot_next;
    end
  end

  // next-state: grant on any eligible warp, chain on fire, revoke on lost eligibility
  always_comb begin
    r_state_next  = r_state;
    r_wid_next    = r_wid;
    r_ptr_next    = r_ptr;
    r_onehot_next = r_onehot;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          r_state_next  = GRANT;
          r_wid_next    = w_pick_idx;
          r_onehot_next = w_pick_onehot;
        end
      end
      GRANT: begin
        if (w_fire) begin
          r_ptr_next = r_wid + WB'(1);
          if (w_pick_valid) begin
            r_wid_next    = w_pick_idx;
            r_onehot_next = w_pick_onehot;
          end else begin
            r_state_next = IDLE;
          end
        end else if (!w_elig[r_wid]) begin
          r_state_next = IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  assign issue_valid  = (r_state == GRANT);
  assign issue_wid    = r_wid;
  assign issue_onehot = r_onehot & {NUM_WARPS{issue_valid}};
  // no pop while reset is asserted: the grant is being discarded
  assign deq          = issue_onehot & {NUM_WARPS{issue_ready & ~reset}};

endmodule
